// File: rtl/inst_fetch_pkg.sv
// ---------------------------------------------------------------------------
// inst_fetch_pkg
//   Shared definitions for the RV32 front end: the canonical NOP encoding,
//   the fetch-stage state encoding, the base opcode constants used by decode,
//   and small helpers for redirect-target alignment.
// ---------------------------------------------------------------------------
package inst_fetch_pkg;

  // addi x0, x0, 0 -- the bubble presented to decode
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Fetch-stage state encoding
  typedef enum logic [1:0] {
    RUN  = 2'd0,  // presenting the word on imem_rdata
    HOLD = 2'd1,  // presenting the captured word while stalled
    KILL = 2'd2   // discarding the in-flight fetch after a redirect/reset
  } fetch_state_e;

  // RV32I base opcodes (bits [6:0] of the instruction word)
  localparam logic [6:0] OPCODE_LUI      = 7'b011_0111;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b001_0111;
  localparam logic [6:0] OPCODE_J_JAL    = 7'b110_1111;
  localparam logic [6:0] OPCODE_I_JALR   = 7'b110_0111;
  localparam logic [6:0] OPCODE_B_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPCODE_I_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPCODE_S_STORE  = 7'b010_0011;
  localparam logic [6:0] OPCODE_I_OPIMM  = 7'b001_0011;
  localparam logic [6:0] OPCODE_R_OP     = 7'b011_0011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b000_1111;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'b111_0011;

  // Force a redirect target onto a word boundary
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // A redirect target with either low bit set is a misaligned target
  function automatic logic addr_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//   Instruction-fetch stage. Owns the fetch PC, drives a synchronous
//   instruction memory with one cycle of read latency, and hands one
//   instruction per cycle (with its PC) to decode. Handles JAL redirects
//   from decode, taken-branch redirects from execute and the load-use stall.
//
// Ports
//   clk          in   pipeline clock
//   rst          in   synchronous active-high reset
//   stall        in   load-use stall: keep presenting the same instruction
//   ID_jmp_vld   in   JAL in decode this cycle
//   ID_jmp_addr  in   JAL offset, target = inst_pc + ID_jmp_addr
//   EX_jmp_vld   in   taken branch resolved in execute this cycle
//   EX_jmp_addr  in   absolute branch target
//   imem_addr    out  word address into instruction memory (from pc_f)
//   imem_rdata   in   instruction word, valid one cycle after imem_addr
//   inst         out  instruction to decode (NOP when a bubble)
//   inst_pc      out  PC of inst
//   inst_vld     out  0 when inst is an inserted bubble
//   misalign     out  sticky: some redirect target had bits [1:0] != 0
// ---------------------------------------------------------------------------
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               ID_jmp_vld,
  input  logic [31:0]        ID_jmp_addr,
  input  logic               EX_jmp_vld,
  input  logic [31:0]        EX_jmp_addr,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        inst,
  output logic [31:0]        inst_pc,
  output logic               inst_vld,
  output logic               misalign
);

  // pc_f: address currently on imem_addr
  // pc_d: PC of the word that memory returns this cycle (and of inst)
  logic [31:0]  pc_f;
  logic [31:0]  pc_d;
  logic [31:0]  hold_q;
  fetch_state_e state;

  // JAL target is relative to the instruction decode is looking at, which
  // is always the one tagged pc_d (whether from memory or from hold_q).
  logic [31:0]  jal_target;

  // JAL target adder; wraps modulo 2^32
  always_comb begin
    jal_target = pc_d + ID_jmp_addr;
  end

  // The memory word address is a straight slice of the registered fetch PC,
  // so it wraps naturally within the memory.
  assign imem_addr = pc_f[IMEM_AW+1:2];
  assign inst_pc   = pc_d;

  // Decode-facing instruction mux. A branch resolved in execute kills the
  // word in this same cycle so a wrong-path instruction never enters decode.
  always_comb begin
    inst     = NOP;
    inst_vld = 1'b0;
    if (EX_jmp_vld) begin
      inst     = NOP;
      inst_vld = 1'b0;
    end else begin
      case (state)
        RUN: begin
          inst     = imem_rdata;
          inst_vld = 1'b1;
        end
        HOLD: begin
          inst     = hold_q;
          inst_vld = 1'b1;
        end
        KILL: begin
          inst     = NOP;
          inst_vld = 1'b0;
        end
        default: begin
          inst     = NOP;
          inst_vld = 1'b0;
        end
      endcase
    end
  end

  // Fetch FSM: PC registers, stall capture, redirect handling, sticky flag
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f     <= RESET_PC;
      pc_d     <= RESET_PC;
      hold_q   <= NOP;
      state    <= KILL;
      misalign <= 1'b0;
    end else if (EX_jmp_vld) begin
      // Execute redirect beats everything, including stall and JAL.
      pc_f  <= word_align(EX_jmp_addr);
      state <= KILL;
      if (addr_misaligned(EX_jmp_addr)) begin
        misalign <= 1'b1;
      end
    end else begin
      case (state)
        KILL: begin
          // The word arriving now belongs to the abandoned path; start the
          // new stream. stall and JAL cannot refer to a bubble.
          pc_d  <= pc_f;
          pc_f  <= pc_f + 32'd4;
          state <= RUN;
        end
        RUN: begin
          if (stall) begin
            // Capture the word now, because memory will move on to pc_f
            // next cycle; pc_f is left alone so that next word is still
            // waiting on imem_rdata when the stall releases.
            hold_q <= imem_rdata;
            state  <= HOLD;
          end else if (ID_jmp_vld) begin
            pc_f  <= word_align(jal_target);
            state <= KILL;
            if (addr_misaligned(jal_target)) begin
              misalign <= 1'b1;
            end
          end else begin
            pc_d <= pc_f;
            pc_f <= pc_f + 32'd4;
          end
        end
        HOLD: begin
          if (stall) begin
            state <= HOLD;
          end else if (ID_jmp_vld) begin
            pc_f  <= word_align(jal_target);
            state <= KILL;
            if (addr_misaligned(jal_target)) begin
              misalign <= 1'b1;
            end
          end else begin
            pc_d  <= pc_f;
            pc_f  <= pc_f + 32'd4;
            state <= RUN;
          end
        end
        default: begin
          state <= KILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch
//   Directed bench for inst_fetch. The instruction memory is a synchronous
//   ROM whose word i holds the value i, so every presented instruction word
//   identifies the address it was fetched from.
// ---------------------------------------------------------------------------
module tb_inst_fetch;

  localparam int          AW      = 10;
  localparam logic [31:0] NOP_ENC = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic          ID_jmp_vld = 1'b0;
  logic [31:0]   ID_jmp_addr = 32'd0;
  logic          EX_jmp_vld = 1'b0;
  logic [31:0]   EX_jmp_addr = 32'd0;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic [31:0]   inst;
  logic [31:0]   inst_pc;
  logic          inst_vld;
  logic          misalign;

  int checks = 0;
  int errors = 0;

  inst_fetch #(.RESET_PC(32'h0000_0000), .IMEM_AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .ID_jmp_vld (ID_jmp_vld),
    .ID_jmp_addr(ID_jmp_addr),
    .EX_jmp_vld (EX_jmp_vld),
    .EX_jmp_addr(EX_jmp_addr),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_vld   (inst_vld),
    .misalign   (misalign)
  );

  always #5 clk = ~clk;

  // ROM[i] = i with one cycle of read latency
  always @(posedge clk) imem_rdata <= {22'd0, imem_addr};

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge; outputs are sampled 1 ns later.
  task automatic step(input logic s, input logic jv, input logic [31:0] ja,
                      input logic ev, input logic [31:0] ea);
    @(negedge clk);
    stall = s; ID_jmp_vld = jv; ID_jmp_addr = ja; EX_jmp_vld = ev; EX_jmp_addr = ea;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic exp_inst(input string tag, input logic [31:0] pc, input logic [31:0] word);
    cmp({tag, ".pc"}, inst_pc, pc);
    cmp({tag, ".inst"}, inst, word);
    cmp({tag, ".vld"}, {31'd0, inst_vld}, 32'd1);
  endtask

  task automatic exp_bubble(input string tag);
    cmp({tag, ".inst"}, inst, NOP_ENC);
    cmp({tag, ".vld"}, {31'd0, inst_vld}, 32'd0);
  endtask

  initial begin
    // Reset held
    repeat (3) @(negedge clk);
    #1;
    exp_bubble("rst");
    cmp("rst.pc", inst_pc, 32'h0);
    cmp("rst.addr", {22'd0, imem_addr}, 32'h0);
    cmp("rst.mis", {31'd0, misalign}, 32'd0);
    rst = 1'b0;
    // The cycle just checked is the boot bubble; free run follows
    idle(); exp_inst("run0", 32'h00, 32'd0);
    idle(); exp_inst("run1", 32'h04, 32'd1);
    // JAL at 0x08, offset 0x20
    step(1'b0, 1'b1, 32'h20, 1'b0, 32'd0); exp_inst("jal_src", 32'h08, 32'd2);
    idle(); exp_bubble("jal_bub");
    idle(); exp_inst("jal_tgt", 32'h28, 32'd10);
    idle(); exp_inst("jal_nxt", 32'h2C, 32'd11);
    idle(); exp_inst("pre_rst", 32'h30, 32'd12);

    // Reset mid-operation
    rst = 1'b1;
    idle();
    exp_bubble("rst2");
    cmp("rst2.pc", inst_pc, 32'h0);
    cmp("rst2.addr", {22'd0, imem_addr}, 32'h0);
    rst = 1'b0;
    idle(); exp_inst("boot2_0", 32'h00, 32'd0);
    idle(); exp_inst("boot2_1", 32'h04, 32'd1);
    idle(); exp_inst("boot2_2", 32'h08, 32'd2);
    idle(); exp_inst("boot2_3", 32'h0C, 32'd3);

    // Branch from execute while inst_pc = 0x10, target 0x40
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'h40);
    exp_bubble("br_same");
    cmp("br_same.pc", inst_pc, 32'h10);
    // stall and JAL during the flush bubble must be ignored
    step(1'b1, 1'b1, 32'h100, 1'b0, 32'd0); exp_bubble("br_bub2");
    idle(); exp_inst("br_tgt", 32'h40, 32'h10);

    // Redirect to 0x14 for the stall test
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'h14); exp_bubble("to14_a");
    idle(); exp_bubble("to14_b");
    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0); exp_inst("stl0", 32'h14, 32'd5);
    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0); exp_inst("stl1", 32'h14, 32'd5);
    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0); exp_inst("stl2", 32'h14, 32'd5);
    idle(); exp_inst("stl3", 32'h14, 32'd5);
    idle(); exp_inst("stl_nxt", 32'h18, 32'd6);

    // stall and branch together in RUN: flush wins
    step(1'b1, 1'b0, 32'd0, 1'b1, 32'h80); exp_bubble("stbr_a");
    idle(); exp_bubble("stbr_b");
    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0); exp_inst("stbr_tgt", 32'h80, 32'h20);
    // now in HOLD: branch with stall still high
    step(1'b1, 1'b0, 32'd0, 1'b1, 32'h80); exp_bubble("hdbr_a");
    idle(); exp_bubble("hdbr_b");
    idle(); exp_inst("hdbr_tgt", 32'h80, 32'h20);
    idle(); exp_inst("hdbr_nxt", 32'h84, 32'h21);

    // Misaligned branch target 0x102
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'h102);
    exp_bubble("mis_a");
    cmp("mis_a.flag", {31'd0, misalign}, 32'd0);
    idle(); exp_bubble("mis_b");
    cmp("mis_b.flag", {31'd0, misalign}, 32'd1);
    idle(); exp_inst("mis_tgt", 32'h100, 32'h40);
    cmp("mis_tgt.flag", {31'd0, misalign}, 32'd1);

    // Wrap-around: branch to 0xFFFF_FFFC, then JAL +8 wraps to 0x4
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC); exp_bubble("wr_a");
    idle(); exp_bubble("wr_b");
    step(1'b0, 1'b1, 32'd8, 1'b0, 32'd0);
    exp_inst("wr_src", 32'hFFFF_FFFC, 32'h3FF);
    cmp("wr_src.addr", {22'd0, imem_addr}, 32'h0);
    idle(); exp_bubble("wr_bub");
    idle(); exp_inst("wr_tgt", 32'h04, 32'd1);
    cmp("wr_tgt.flag", {31'd0, misalign}, 32'd1);

    // Only reset clears the sticky flag
    rst = 1'b1;
    idle();
    cmp("rst3.flag", {31'd0, misalign}, 32'd0);
    cmp("rst3.pc", inst_pc, 32'h0);
    exp_bubble("rst3");
    rst = 1'b0;
    idle(); exp_inst("boot3_0", 32'h00, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage of the RV32 pipeline, directly upstream of the decode stage. Owns the fetch PC and drives a synchronous instruction memory (1-cycle read latency). Presents one instruction per cycle, with its PC, to decode. Handles redirects from decode (JAL) and execute (taken branch), and the load-use stall from the hazard logic.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned).
- IMEM_AW, 10, instruction-memory word-address width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  load-use stall from hazard logic; decode must see the same instruction next cycle.
- ID_jmp_vld  in  1  JAL in decode (combinational from decode).
- ID_jmp_addr  in  32  JAL PC-relative offset; target = inst_pc + ID_jmp_addr.
- EX_jmp_vld  in  1  taken branch resolved in execute.
- EX_jmp_addr  in  32  absolute branch target.
- imem_addr  out  IMEM_AW  word address, = pc_f[IMEM_AW+1:2] (registered).
- imem_rdata  in  32  instruction word, valid one cycle after imem_addr.
- inst  out  32  instruction to decode.
- inst_pc  out  32  PC of inst.
- inst_vld  out  1  0 when inst is an inserted bubble.
- misalign  out  1  sticky flag: a redirect target had bits [1:0] != 0.

## Operation
- Registers: pc_f (fetch address), pc_d (PC of the word on imem_rdata), hold_q (stalled instruction), state, misalign.
- States: RUN, HOLD, KILL. Reset enters KILL.
- Bubble: inst = NOP (32'h0000_0013), inst_vld = 0, inst_pc = pc_d.
- KILL: output bubble; pc_d <= pc_f; pc_f <= pc_f+4; go to RUN. Inputs stall and ID_jmp_vld are ignored.
- RUN: inst = imem_rdata, inst_pc = pc_d, inst_vld = 1. Priority: EX redirect > stall > ID redirect > sequential.
  - stall: hold_q <= imem_rdata; pc_f and pc_d hold; go to HOLD.
  - ID_jmp_vld: pc_f <= pc_d + ID_jmp_addr; go to KILL.
  - otherwise: pc_d <= pc_f; pc_f <= pc_f+4.
- HOLD: inst = hold_q, inst_pc = pc_d, inst_vld = 1.
  - stall high: stay in HOLD.
  - stall low with ID_jmp_vld: take the jump as in RUN and go to KILL.
  - stall low otherwise: pc_d <= pc_f; pc_f <= pc_f+4; go to RUN.
- EX_jmp_vld, in any state:
  - Force the bubble on inst combinationally in the same cycle, so the wrong-path instruction never reaches decode.
  - pc_f <= EX_jmp_addr; go to KILL.
  - Overrides stall and ID_jmp_vld.
- Redirect targets: bits [1:0] are cleared before loading pc_f. If either bit was set, misalign <= 1 and stays set until rst.
- Arithmetic: all PC adds are 32-bit modulo 2^32. imem_addr wraps within 2^IMEM_AW words.

## Timing
- Values held while rst is high:
  - pc_f = pc_d = RESET_PC, state = KILL.
  - inst = NOP, inst_vld = 0, inst_pc = RESET_PC.
  - imem_addr = RESET_PC[IMEM_AW+1:2], misalign = 0.
- Boot: first cycle after rst deasserts is a bubble. The instruction at RESET_PC is presented on the second cycle.
- Throughput: one instruction per cycle in RUN.
- JAL penalty: 1 bubble. JAL in decode at cycle t → bubble at t+1 → target instruction at t+2.
- Branch penalty: 2 bubbles. EX_jmp_vld at t → bubbles at t and t+1 → target instruction at t+2.
- Stall for n cycles starting at t: the same inst/inst_pc is held for cycles t..t+n. The next sequential instruction follows at t+n+1, with no bubble and no lost instruction.
- Reset mid-operation (any state): next cycle equals the post-reset values above; hold_q and in-flight fetches are discarded.
- Paths: EX_jmp_vld → inst is combinational. ID_jmp_vld and stall affect registers only.

## Structure
- The shared defines file holds:
  - the NOP encoding;
  - the state encodings RUN/HOLD/KILL;
  - OPCODE_J_JAL and the other opcode constants, which decode already uses from there.
- Single module, no sub-modules. The next-PC mux plus adder is small enough to stay inline.

## Test plan
- Reset then free run, RESET_PC = 0, ROM[i] = i:
  - one bubble after reset;
  - then inst_pc = 0, 4, 8 … on consecutive cycles with inst = 0, 1, 2 …
- JAL at PC 0x08 with offset 0x20: inst_pc sequence 0x08, bubble, 0x28, 0x2C.
- EX_jmp_vld while inst_pc = 0x10, EX_jmp_addr = 0x40:
  - inst = NOP in that same cycle;
  - then one more bubble, then inst_pc = 0x40.
- stall high for 3 cycles while inst_pc = 0x14:
  - inst_pc = 0x14 for 4 cycles with an unchanged inst word;
  - then 0x18 with no bubble.
- stall and EX_jmp_vld in the same cycle (target 0x80): the flush wins; two bubbles, then 0x80. Same check with EX_jmp_vld arriving while in HOLD.
- Misaligned and wrap-around targets:
  - EX_jmp_addr = 0x102: misalign = 1, then inst_pc = 0x100; misalign stays 1 until rst.
  - JAL at 0xFFFF_FFFC with offset 8 wraps to inst_pc = 0x4.
